// File: rtl/button_event_fsm_if.sv
// Event bundle between the button event FSM and its consumers.
//
// Handshake: every strobe (press/release/long/repeat) is valid for exactly one
// clock cycle and has no ready; consumers must sample it on that cycle.
// held and press_count are level signals that are valid on every cycle.
// btn_level is driven by the debouncer and is already synchronous to clk.
interface button_event_fsm_if #(
  parameter int unsigned CNT_W = 8
);
  logic             btn_level;
  logic             press_pulse;
  logic             release_pulse;
  logic             long_pulse;
  logic             repeat_pulse;
  logic             held;
  logic [CNT_W-1:0] press_count;
  logic [1:0]       state_dbg;

  // Event producer: the FSM itself.
  modport master (
    input  btn_level,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output repeat_pulse,
    output held,
    output press_count,
    output state_dbg
  );

  // Event consumer side, which also supplies the debounced level.
  modport slave (
    output btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  repeat_pulse,
    input  held,
    input  press_count,
    input  state_dbg
  );
endinterface

// File: rtl/button_event_fsm.sv
// Turns the debounced button level into single-cycle press, release,
// long-press and auto-repeat strobes, plus a wrapping press counter.
// All outputs are registered; the current FSM state is exported on
// bus.state_dbg for observation.
module button_event_fsm #(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  button_event_fsm_if.master     bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  // Terminal counts: the timer starts at 0 on entry, so the event fires on
  // the edge where the timer reads N-1, i.e. exactly N clocks after entry.
  localparam logic [31:0] LONG_TERM   = 32'(LONG_CYCLES - 1);
  localparam logic [31:0] REPEAT_TERM = 32'(REPEAT_CYCLES - 1);
  localparam logic [31:0] TIMER_MAX   = 32'hFFFF_FFFF;

  state_t           state_q, state_d;
  logic [31:0]      timer_q, timer_d;
  logic             btn_q;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             rise;
  logic             fall;
  logic [31:0]      timer_inc;

  assign rise = bus.btn_level & ~btn_q;
  assign fall = ~bus.btn_level & btn_q;

  // Timer saturates instead of wrapping; in practice the terminal counts
  // clear it long before the ceiling is reached.
  assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : (timer_q + 32'd1);

  // State, timer, edge detector and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= 32'd0;
      btn_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      btn_q     <= bus.btn_level;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
      count_q   <= count_d;
    end
  end

  // Next-state and next-output decode; release takes priority over the
  // long/repeat terminal count when both happen on the same edge.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    count_d   = count_q;

    case (state_q)
      IDLE: begin
        timer_d = 32'd0;
        if (rise) begin
          state_d = PRESSED;
          press_d = 1'b1;
          count_d = count_q + CNT_W'(1);
        end
      end

      PRESSED: begin
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
          timer_d   = 32'd0;
        end else if (timer_q == LONG_TERM) begin
          state_d = LONG;
          long_d  = 1'b1;
          timer_d = 32'd0;
        end else begin
          timer_d = timer_inc;
        end
      end

      LONG: begin
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
          timer_d   = 32'd0;
        end else if (timer_q == REPEAT_TERM) begin
          repeat_d = 1'b1;
          timer_d  = 32'd0;
        end else begin
          timer_d = timer_inc;
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = 32'd0;
      end
    endcase

    held_d = (state_d != IDLE);
  end

  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.long_pulse    = long_q;
  assign bus.repeat_pulse  = repeat_q;
  assign bus.held          = held_q;
  assign bus.press_count   = count_q;
  assign bus.state_dbg     = state_q;

endmodule
